// File: rtl/ber_checker_pkg.sv
// Shared constants for the BER checker: FSM state encodings and the PRBS9 period
// that bounds the latency search.
package ber_checker_pkg;

  localparam int PRBS9_PERIOD = 511;

  typedef logic [1:0] state_t;

  localparam state_t ST_SKIP   = 2'd0;
  localparam state_t ST_SEARCH = 2'd1;
  localparam state_t ST_LOCK   = 2'd2;
  localparam state_t ST_COUNT  = 2'd3;

endpackage

// File: rtl/ber_checker_bit_delay_line.sv
// Enable-gated 1-bit shift register of transmit history with a selectable tap.
// Tap k holds the bit shifted in k+1 enables ago; reset clears it to zero.
module bit_delay_line #(
  parameter int DEPTH  = 512,
  parameter int NB_SEL = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              din,
  input  logic [NB_SEL-1:0] sel,
  output logic              dout
);

  logic [DEPTH-1:0] dl;

  always_ff @(posedge clk) begin
    if (reset) begin
      dl <= '0;
    end else if (enable) begin
      dl <= {dl[DEPTH-2:0], din};
    end
  end

  assign dout = dl[sel];

endmodule

// File: rtl/ber_checker.sv
// Single-lane BER checker: skips the equaliser settling period, searches for the
// tx-to-rx latency with the fewest errors, locks to it, then counts errors/bits.
module ber_checker
  import ber_checker_pkg::*;
#(
  parameter int NBT_SYM    = 12,
  parameter int MAX_DELAY  = PRBS9_PERIOD,
  parameter int SKIP_SYMS  = 1024,
  parameter int SEARCH_LEN = 256,
  parameter int NB_CNT     = 32
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_tx_bit,
  input  logic [NBT_SYM-1:0] i_rx_sym,
  output logic               o_locked,
  output logic [8:0]         o_delay,
  output logic [NB_CNT-1:0]  o_err_count,
  output logic [NB_CNT-1:0]  o_bit_count
);

  localparam int NB_ACC = $clog2(SEARCH_LEN + 1);
  localparam int NB_SYM = $clog2(((SKIP_SYMS > SEARCH_LEN) ? SKIP_SYMS : SEARCH_LEN) + 1);

  state_t            state;
  logic [NB_SYM-1:0] cnt;
  logic [NB_ACC-1:0] err_acc;
  logic [NB_ACC-1:0] best_err;
  logic [NB_ACC-1:0] err_final;
  logic [8:0]        cand_d;
  logic [8:0]        best_d;
  logic [8:0]        sel;
  logic              tap_bit;
  logic              rx_bit;
  logic              mismatch;
  logic              unused_sym_bits;

  // Only the sign of the slicer decision carries the bit; negative means 1.
  assign rx_bit          = i_rx_sym[NBT_SYM-1];
  assign unused_sym_bits = ^i_rx_sym[NBT_SYM-2:0];

  // One tap serves both phases: the candidate during search, the locked delay afterwards.
  assign sel       = (state == ST_COUNT) ? o_delay : cand_d;
  assign mismatch  = rx_bit ^ tap_bit;
  assign err_final = err_acc + NB_ACC'(mismatch);

  bit_delay_line #(
    .DEPTH  (MAX_DELAY + 1),
    .NB_SEL (9)
  ) u_delay_line (
    .clk    (clk),
    .reset  (i_reset),
    .enable (i_enable),
    .din    (i_tx_bit),
    .sel    (sel),
    .dout   (tap_bit)
  );

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state       <= ST_SKIP;
      cnt         <= '0;
      err_acc     <= '0;
      best_err    <= '0;
      cand_d      <= '0;
      best_d      <= '0;
      o_locked    <= 1'b0;
      o_delay     <= '0;
      o_err_count <= '0;
      o_bit_count <= '0;
    end else if (i_enable) begin
      case (state)
        ST_SKIP: begin
          if (cnt == NB_SYM'(SKIP_SYMS - 1)) begin
            state    <= ST_SEARCH;
            cnt      <= '0;
            err_acc  <= '0;
            cand_d   <= '0;
            best_d   <= '0;
            best_err <= '1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SEARCH: begin
          if (cnt == NB_SYM'(SEARCH_LEN - 1)) begin
            // Strict less-than keeps the lowest delay on ties.
            if (err_final == '0) begin
              best_d <= cand_d;
              state  <= ST_LOCK;
            end else begin
              if (err_final < best_err) begin
                best_err <= err_final;
                best_d   <= cand_d;
              end
              if (cand_d == 9'(MAX_DELAY)) begin
                state <= ST_LOCK;
              end else begin
                cand_d  <= cand_d + 9'd1;
                err_acc <= '0;
                cnt     <= '0;
              end
            end
          end else begin
            err_acc <= err_final;
            cnt     <= cnt + 1'b1;
          end
        end
        ST_LOCK: begin
          o_delay  <= best_d;
          o_locked <= 1'b1;
          state    <= ST_COUNT;
        end
        ST_COUNT: begin
          // Freezing both counters once bits saturate keeps the ratio meaningful.
          if (o_bit_count != '1) begin
            o_bit_count <= o_bit_count + 1'b1;
            if (mismatch && (o_err_count != '1)) begin
              o_err_count <= o_err_count + 1'b1;
            end
          end
        end
        default: state <= ST_SKIP;
      endcase
    end
  end

endmodule
